run_detect_n: RTL and testbench
===============================

# run_detect_n

Parametrised run-length detector: the generalised successor of the team's fixed four-in-a-row ones/zeros detector. It samples a serial bit `W` on enabled clock edges and tracks the value and length of the current run of identical bits. It asserts `Z` once `RUN_LEN` consecutive equal bits have been seen, subject to a run-polarity mode. It also counts detection events. It sits between the debounced switch/key front end and the LED/7-seg display logic on the board top level.

## Interface
- `RUN_LEN`, 4: consecutive equal samples required for detection; legal range 2..255.
- `HIT_W`, 8: width of the detection-event counter.
- `LEN_W`, derived as $clog2(RUN_LEN+1): width of `RunLen`. Local, not overridable.

Ports:
- `Clk`  in  1: single clock; all state changes on the rising edge.
- `Resetn`  in  1: asynchronous, active-low reset.
- `En`  in  1: sample enable; `W` is consumed only on edges where `En`=1.
- `W`  in  1: serial input bit.
- `Mode`  in  2: polarity select.
  - 00: detect runs of either polarity.
  - 01: ones only.
  - 10: zeros only.
  - 11: detection disabled.
- `ClrCnt`  in  1: synchronous clear of `HitCnt`.
- `Z`  out  1: registered detect flag.
- `RunVal`  out  1: bit value of the current run.
- `RunLen`  out  LEN_W: length of the current run; saturates at RUN_LEN.
- `HitCnt`  out  HIT_W: number of 0->1 transitions of `Z`; wraps modulo 2^HIT_W.

## Operation
- **Empty state.** `RunLen`=0 means no sample has been taken since reset.
- **Enabled edge, run breaks.** If `RunLen`=0 or `W`≠`RunVal`: `RunVal`<=`W` and `RunLen`<=1.
- **Enabled edge, run continues.** Otherwise `RunLen`<=min(`RunLen`+1, RUN_LEN).
- **Disabled edge.** `RunVal` and `RunLen` hold.
- **Detect flag.** Every edge, regardless of `En`: `Z`<=accept(`Mode`, next `RunVal`) AND (next `RunLen`==RUN_LEN).
  - accept is true for `Mode` 00.
  - accept is true for `Mode` 01 when the run value is 1.
  - accept is true for `Mode` 10 when the run value is 0.
  - accept is false for `Mode` 11.
- **Hold while run continues.** `Z` stays high for as long as the run continues; there is no retrigger or overlap logic. This matches the existing detector.
- **Polarity flip at saturation.** When a run breaks, `RunLen` becomes 1, so `Z` falls on that edge because RUN_LEN ≥ 2. A saturated run of ones directly followed by zeros needs RUN_LEN fresh zeros before `Z` can rise again.
- **Hit counting.** `HitCnt` increments on every edge where next `Z`=1 and current `Z`=0.
  - `ClrCnt`=1 forces `HitCnt`<=0 and has priority over a simultaneous increment; that increment is lost.
  - `Z` itself is unaffected by `ClrCnt`.
- **Mode changes.**
  - A change takes effect at the next edge, even with `En`=0.
  - Enabling a polarity during an already-saturated run raises `Z` and counts one hit.
  - Disabling it drops `Z` and leaves the run state intact.

## Timing
- **Reset values.** `Z`=0, `RunVal`=0, `RunLen`=0, `HitCnt`=0. They apply asynchronously while `Resetn`=0.
- **Reset mid-run.** Discards the run entirely; the next enabled sample starts a new run of length 1.
- **Detection latency.** `Z` rises at the same edge that captures the RUN_LEN-th consecutive equal enabled sample. It is visible in the following cycle; there are no combinational paths from inputs to outputs.
- **`HitCnt` timing.** `HitCnt` updates on the same edge as `Z`'s rising transition.
- **Non-contiguous `En`.** Gaps in `En` do not break a run; only a differing sampled bit does.
- **`HitCnt` wrap.** 2^HIT_W−1 + 1 -> 0, no flag.

## Structure
- **Shared package `run_detect_pkg`:** the `Mode` encodings as named constants `MODE_BOTH`, `MODE_ONES`, `MODE_ZEROS`, `MODE_OFF`, and a `mode_accept(mode, bit)` function. The display top level reuses these.
- **Sub-module `wrap_counter`:** holds `HitCnt` — a HIT_W-bit counter with increment and priority synchronous clear, sharing `Clk`/`Resetn`.
- **Main body:** run tracking and the `Z` register stay in the main module.

## Test plan
All scenarios use RUN_LEN=4 and HIT_W=8.
- **Reset.** Assert `Resetn`=0 mid-run with `RunLen`=3 -> all outputs 0 immediately. The first enabled sample after release gives `RunLen`=1.
- **Ones run, `Mode`=00.** `W`=1,1,1,1,1,0 on enabled edges.
  - `Z` rises after the 4th edge and stays high after the 5th.
  - `Z` falls after the 6th, with `RunVal`=0 and `RunLen`=1.
  - `HitCnt`=1.
- **Mode filter.** `Mode`=01 with 4 zeros -> `Z`=0, `RunLen`=4. Then switch `Mode` to 10 with `En`=0 -> `Z`=1 next edge, `HitCnt`+1.
- **`En` gaps.** `W`=0 with `En` pattern 1,0,1,0,0,1,1 -> `Z` rises at the 4th enabled edge, not before. With `W`≠`RunVal` but `En`=0, there is no change.
- **`Mode`=11.** 10 ones -> `Z` stays 0, `RunLen` saturates at 4, `HitCnt` unchanged.
- **Counter.**
  - Preload 255 hits, then produce one more detection -> `HitCnt`=0.
  - `ClrCnt`=1 on a rising-`Z` edge -> `HitCnt`=0 and `Z`=1.

Source files
------------

// File: rtl/run_detect_pkg.sv
// run_detect_pkg
// Shared definitions for the run-length detector and the display top level.
//   MODE_BOTH / MODE_ONES / MODE_ZEROS / MODE_OFF : encodings of the 2-bit
//     polarity-select input.
//   mode_accept(mode, b) : true when a run of value b may raise the detect
//     flag under the given polarity mode.
package run_detect_pkg;

  localparam logic [1:0] MODE_BOTH  = 2'b00;
  localparam logic [1:0] MODE_ONES  = 2'b01;
  localparam logic [1:0] MODE_ZEROS = 2'b10;
  localparam logic [1:0] MODE_OFF   = 2'b11;

  function automatic logic mode_accept(input logic [1:0] mode, input logic b);
    logic acc;
    case (mode)
      MODE_BOTH:  acc = 1'b1;
      MODE_ONES:  acc = b;
      MODE_ZEROS: acc = ~b;
      default:    acc = 1'b0;
    endcase
    return acc;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// wrap_counter
// Free-running event counter that wraps modulo 2^WIDTH.
//   Clk    : clock, rising edge
//   Resetn : asynchronous active-low reset, clears the count
//   inc    : add one on this edge
//   clr    : synchronous clear; wins over a simultaneous inc
//   cnt    : current count
module wrap_counter #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Resetn,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      // Natural overflow gives the modulo-2^WIDTH wrap, no flag.
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/run_detect_n.sv
// run_detect_n
// Parametrised run-length detector. Samples W on edges with En=1, tracks the
// value and (saturating) length of the current run of identical bits, and
// raises Z once RUN_LEN equal samples have been seen and the run polarity is
// accepted by Mode. Rising edges of Z are counted in HitCnt.
//   Clk    : clock, rising edge
//   Resetn : asynchronous active-low reset
//   En     : sample enable for W
//   W      : serial input bit
//   Mode   : polarity select (see run_detect_pkg)
//   ClrCnt : synchronous clear of HitCnt (priority over increment)
//   Z      : registered detect flag
//   RunVal : value of the current run
//   RunLen : length of the current run, saturating at RUN_LEN (0 = empty)
//   HitCnt : number of 0->1 transitions of Z, wrapping
module run_detect_n
  import run_detect_pkg::*;
#(
  parameter  int RUN_LEN = 4,
  parameter  int HIT_W   = 8,
  localparam int LEN_W   = $clog2(RUN_LEN + 1)
) (
  input  logic             Clk,
  input  logic             Resetn,
  input  logic             En,
  input  logic             W,
  input  logic [1:0]       Mode,
  input  logic             ClrCnt,
  output logic             Z,
  output logic             RunVal,
  output logic [LEN_W-1:0] RunLen,
  output logic [HIT_W-1:0] HitCnt
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(RUN_LEN);

  logic             nxt_val;
  logic [LEN_W-1:0] nxt_len;
  logic             nxt_z;
  logic             hit;

  // Next run state. RunLen==0 marks "no sample yet", so the first sample
  // always starts a run regardless of the reset value of RunVal.
  always_comb begin
    nxt_val = RunVal;
    nxt_len = RunLen;
    if (En) begin
      if ((RunLen == '0) || (W != RunVal)) begin
        nxt_val = W;
        nxt_len = LEN_W'(1);
      end else if (RunLen != LEN_MAX) begin
        nxt_len = RunLen + LEN_W'(1);
      end
    end
    // Evaluated every edge so Mode changes act even while En=0.
    nxt_z = mode_accept(Mode, nxt_val) && (nxt_len == LEN_MAX);
  end

  assign hit = nxt_z & ~Z;

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      RunVal <= 1'b0;
      RunLen <= '0;
      Z      <= 1'b0;
    end else begin
      RunVal <= nxt_val;
      RunLen <= nxt_len;
      Z      <= nxt_z;
    end
  end

  wrap_counter #(
    .WIDTH (HIT_W)
  ) u_hit_cnt (
    .Clk    (Clk),
    .Resetn (Resetn),
    .inc    (hit),
    .clr    (ClrCnt),
    .cnt    (HitCnt)
  );

endmodule

// File: tb/tb_run_detect_n.sv
module tb_run_detect_n;

  localparam int RUN_LEN = 4;
  localparam int HIT_W   = 8;
  localparam int LEN_W   = $clog2(RUN_LEN + 1);

  // ---------------- clock / reset / DUT ----------------
  logic             Clk    = 1'b0;
  logic             Resetn = 1'b0;
  logic             En     = 1'b0;
  logic             W      = 1'b0;
  logic [1:0]       Mode   = 2'b00;
  logic             ClrCnt = 1'b0;
  logic             Z;
  logic             RunVal;
  logic [LEN_W-1:0] RunLen;
  logic [HIT_W-1:0] HitCnt;

  always #5 Clk = ~Clk;

  run_detect_n #(
    .RUN_LEN (RUN_LEN),
    .HIT_W   (HIT_W)
  ) dut (
    .Clk    (Clk),
    .Resetn (Resetn),
    .En     (En),
    .W      (W),
    .Mode   (Mode),
    .ClrCnt (ClrCnt),
    .Z      (Z),
    .RunVal (RunVal),
    .RunLen (RunLen),
    .HitCnt (HitCnt)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // The model keeps the recent enabled samples in a queue and derives the
  // run from them: value is the last sample, length is the count of
  // trailing samples equal to it, capped at RUN_LEN.
  int hist[$];
  int m_z   = 0;
  int m_cnt = 0;

  function automatic int m_val();
    if (hist.size() == 0) return 0;
    return hist[hist.size()-1];
  endfunction

  function automatic int m_len();
    int n;
    int last;
    n = 0;
    if (hist.size() == 0) return 0;
    last = hist[hist.size()-1];
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != last) break;
      n++;
    end
    return (n > RUN_LEN) ? RUN_LEN : n;
  endfunction

  function automatic int accept(input int mode, input int v);
    if (mode == 0) return 1;
    if (mode == 1) return (v == 1) ? 1 : 0;
    if (mode == 2) return (v == 0) ? 1 : 0;
    return 0;
  endfunction

  task automatic model_edge(input bit en, input bit w, input int mode, input bit clr);
    int nz;
    if (en) begin
      hist.push_back(int'(w));
      if (hist.size() > RUN_LEN + 1) void'(hist.pop_front());
    end
    nz = (accept(mode, m_val()) != 0 && m_len() == RUN_LEN) ? 1 : 0;
    if (clr) m_cnt = 0;
    else if (nz == 1 && m_z == 0) m_cnt = (m_cnt + 1) % (1 << HIT_W);
    m_z = nz;
  endtask

  task automatic model_reset();
    hist.delete();
    m_z   = 0;
    m_cnt = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".z"},      32'(Z),      32'(m_z));
    check({tag, ".runval"}, 32'(RunVal), 32'(m_val()));
    check({tag, ".runlen"}, 32'(RunLen), 32'(m_len()));
    check({tag, ".hitcnt"}, 32'(HitCnt), 32'(m_cnt));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input string tag, input bit en, input bit w,
                      input logic [1:0] mode, input bit clr = 1'b0);
    @(negedge Clk);
    En     = en;
    W      = w;
    Mode   = mode;
    ClrCnt = clr;
    @(posedge Clk);
    model_edge(en, w, int'(mode), clr);
    #1;
    check_all(tag);
  endtask

  // Asserts reset between edges and checks the outputs clear asynchronously.
  task automatic do_reset(input string tag);
    @(negedge Clk);
    Resetn = 1'b0;
    En     = 1'b0;
    ClrCnt = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge Clk);
    @(negedge Clk);
    Resetn = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int  base_cnt;
  int  iter;
  bit  rw;
  bit  ren;
  bit  rclr;
  logic [1:0] rmode;

  initial begin
    // Reset state
    #1;
    check_all("por");
    @(negedge Clk);
    Resetn = 1'b1;

    // Reset mid-run with RunLen=3
    for (int i = 0; i < 3; i++) step("pre_reset", 1'b1, 1'b1, 2'b00);
    check("mid_run_len", 32'(RunLen), 32'd3);
    do_reset("mid_reset");
    check("reset_z_zero", 32'(Z), 32'd0);
    check("reset_len_zero", 32'(RunLen), 32'd0);
    step("first_after_reset", 1'b1, 1'b1, 2'b00);
    check("first_len_one", 32'(RunLen), 32'd1);

    // Ones run, Mode=00: W=1,1,1,1,1,0
    do_reset("reset2");
    for (int i = 0; i < 3; i++) step("ones", 1'b1, 1'b1, 2'b00);
    check("ones_z_before", 32'(Z), 32'd0);
    step("ones4", 1'b1, 1'b1, 2'b00);
    check("ones_z_rise", 32'(Z), 32'd1);
    step("ones5", 1'b1, 1'b1, 2'b00);
    check("ones_z_hold", 32'(Z), 32'd1);
    step("ones_break", 1'b1, 1'b0, 2'b00);
    check("break_z", 32'(Z), 32'd0);
    check("break_val", 32'(RunVal), 32'd0);
    check("break_len", 32'(RunLen), 32'd1);
    check("break_hits", 32'(HitCnt), 32'd1);

    // Mode filter: ones-only with zeros, then switch to zeros-only with En=0
    step("filt_brk", 1'b1, 1'b1, 2'b01);
    for (int i = 0; i < 4; i++) step("filt", 1'b1, 1'b0, 2'b01);
    check("filt_z", 32'(Z), 32'd0);
    check("filt_len", 32'(RunLen), 32'd4);
    base_cnt = int'(HitCnt);
    step("filt_sw", 1'b0, 1'b1, 2'b10);
    check("filt_sw_z", 32'(Z), 32'd1);
    check("filt_sw_hits", 32'(HitCnt), 32'((base_cnt + 1) % 256));

    // En gaps: W=0 with En 1,0,1,0,0,1,1
    step("gap_brk", 1'b1, 1'b1, 2'b00);
    step("gap1", 1'b1, 1'b0, 2'b00);
    step("gap2", 1'b0, 1'b0, 2'b00);
    step("gap3", 1'b1, 1'b0, 2'b00);
    step("gap4", 1'b0, 1'b0, 2'b00);
    step("gap5", 1'b0, 1'b0, 2'b00);
    step("gap6", 1'b1, 1'b0, 2'b00);
    check("gap_z_before", 32'(Z), 32'd0);
    step("gap7", 1'b1, 1'b0, 2'b00);
    check("gap_z_rise", 32'(Z), 32'd1);
    step("gap_diff_noen", 1'b0, 1'b1, 2'b00);
    check("gap_hold_val", 32'(RunVal), 32'd0);
    check("gap_hold_len", 32'(RunLen), 32'd4);

    // Mode=11: ten ones
    base_cnt = int'(HitCnt);
    for (int i = 0; i < 10; i++) step("off", 1'b1, 1'b1, 2'b11);
    check("off_z", 32'(Z), 32'd0);
    check("off_len", 32'(RunLen), 32'd4);
    check("off_hits", 32'(HitCnt), 32'(base_cnt));

    // Counter preload to 255 by toggling acceptance on a saturated run
    iter = 0;
    while (iter < 600) begin
      step("preload_on", 1'b0, 1'b1, 2'b00);
      if (m_cnt == 255) break;
      step("preload_off", 1'b0, 1'b1, 2'b11);
      iter++;
    end
    check("preload_255", 32'(HitCnt), 32'd255);
    step("wrap_off", 1'b0, 1'b1, 2'b11);
    step("wrap_on", 1'b1, 1'b1, 2'b01);
    check("wrap_zero", 32'(HitCnt), 32'd0);
    check("wrap_z", 32'(Z), 32'd1);

    // ClrCnt on a rising-Z edge
    step("clr_pre", 1'b0, 1'b1, 2'b00);
    step("clr_off", 1'b0, 1'b1, 2'b11);
    step("clr_rise", 1'b0, 1'b1, 2'b00, 1'b1);
    check("clr_hits", 32'(HitCnt), 32'd0);
    check("clr_z", 32'(Z), 32'd1);

    // Randomized phase
    rw    = 1'b0;
    rmode = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rw = ~rw;
      ren  = ($urandom_range(0, 3) != 0);
      rclr = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 7) == 0) rmode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) begin
        do_reset("rnd_reset");
      end else begin
        step("rnd", ren, rw, rmode, rclr);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
